// File: rtl/cp0_fwd_tracker.sv
// CP0 forwarding / interlock tracker. Sits beside ID and keeps a private shift
// register of in-flight mtc0 writes and barriers. An mfc0 or eret in ID is
// served the youngest pending write to the same register. Registers the
// hardware updates on its own (NOFWD_MASK) are never forwarded; ID stalls
// until the pending write retires instead.
module cp0_fwd_tracker #(
    parameter int          DEPTH      = 3,
    parameter int          DW         = 32,
    parameter logic [31:0] NOFWD_MASK = 32'h0000_2200,
    parameter logic [4:0]  EPC_CS     = 5'd14,
    parameter logic [2:0]  EPC_SEL    = 3'd0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hold,
    input  logic [DEPTH:0]             flush,
    input  logic                       id_valid,
    input  logic [2:0]                 id_cp0op,
    input  logic [4:0]                 id_cs,
    input  logic [2:0]                 id_sel,
    input  logic [DW-1:0]              id_wdata,
    output logic [$clog2(DEPTH+1)-1:0] fwd_stage,
    output logic [DW-1:0]              fwd_data,
    output logic                       cp0_stall,
    output logic [$clog2(DEPTH+1)-1:0] pending_cnt
);
    localparam int SW = $clog2(DEPTH+1);
    localparam logic [2:0] OP_MFC0 = 3'b001;
    localparam logic [2:0] OP_MTC0 = 3'b010;
    localparam logic [2:0] OP_BAR  = 3'b011;
    localparam logic [2:0] OP_ERET = 3'b100;

    // Entry k (1 = EX ... DEPTH = WB)
    logic [DEPTH:1]         e_v;
    logic [DEPTH:1][2:0]    e_op;
    logic [DEPTH:1][4:0]    e_cs;
    logic [DEPTH:1][2:0]    e_sel;
    logic [DEPTH:1][DW-1:0] e_data;

    logic [4:0]    tgt_cs;
    logic [2:0]    tgt_sel;
    logic          lookup;
    logic          blocked;
    logic [SW-1:0] hit;
    logic [DW-1:0] hit_data;
    logic          nofwd;
    logic          capture;
    logic [DEPTH:1] v_kept;
    logic [DEPTH:1] v_nxt;
    logic [SW-1:0]  cnt_nxt;

    // Lookup: youngest matching mtc0, ignoring anything older than a barrier
    always_comb begin
        tgt_cs   = (id_cp0op == OP_ERET) ? EPC_CS  : id_cs;
        tgt_sel  = (id_cp0op == OP_ERET) ? EPC_SEL : id_sel;
        lookup   = id_valid && !flush[0] &&
                   (id_cp0op == OP_MFC0 || id_cp0op == OP_ERET);
        blocked  = 1'b0;
        hit      = '0;
        hit_data = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (lookup && !blocked && hit == '0 && e_v[k] && e_op[k] == OP_MTC0 &&
                e_cs[k] == tgt_cs && e_sel[k] == tgt_sel) begin
                hit      = SW'(k);
                hit_data = e_data[k];
            end
            if (e_v[k] && e_op[k] == OP_BAR)
                blocked = 1'b1;
        end
        nofwd     = (tgt_sel == 3'd0) && NOFWD_MASK[tgt_cs] && (hit != '0);
        cp0_stall = nofwd;
        fwd_stage = nofwd ? '0 : hit;
        fwd_data  = nofwd ? '0 : hit_data;
    end

    // Next valid bits: flush first, then shift when not held; count pending mtc0s
    always_comb begin
        capture = id_valid && !flush[0] && !nofwd &&
                  (id_cp0op == OP_MTC0 || id_cp0op == OP_BAR);
        v_kept  = e_v & ~flush[DEPTH:1];
        v_nxt   = v_kept;
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--)
                v_nxt[k] = v_kept[k-1];
            v_nxt[1] = capture;
        end
        cnt_nxt = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (v_nxt[k] && (hold ? e_op[k] : (k == 1 ? id_cp0op : e_op[k-1])) == OP_MTC0)
                cnt_nxt = cnt_nxt + SW'(1);
        end
    end

    // Valid bits and pending count; reset discards everything in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_v         <= '0;
            pending_cnt <= '0;
        end else begin
            e_v         <= v_nxt;
            pending_cnt <= cnt_nxt;
        end
    end

    // Entry payload shifts with the pipeline; only meaningful where valid
    always_ff @(posedge clk) begin
        if (!hold) begin
            for (int k = DEPTH; k >= 2; k--) begin
                e_op[k]   <= e_op[k-1];
                e_cs[k]   <= e_cs[k-1];
                e_sel[k]  <= e_sel[k-1];
                e_data[k] <= e_data[k-1];
            end
            e_op[1]   <= id_cp0op;
            e_cs[1]   <= id_cs;
            e_sel[1]  <= id_sel;
            e_data[1] <= id_wdata;
        end
    end
endmodule

// File: doc/cp0_fwd_tracker.md
# cp0_fwd_tracker

Parametrised CP0 forwarding and interlock unit for the pipelined MIPS core, sitting beside the ID stage. It keeps its own shift register of in-flight CP0 operations (mtc0 data, barriers) instead of taking per-stage opcode and address inputs. It serves the youngest matching pending mtc0 value to an mfc0 or eret in ID. When forwarding is illegal (hardware-updated registers), it raises a stall until the write retires.

## Interface
- DEPTH, 3: pipeline stages tracked after ID (EX=1 … WB=DEPTH)
- DW, 32: CP0 data width
- NOFWD_MASK, 32'h0000_2200: bit *n* set means CP0 register *n* (sel 0 only) must never be forwarded (Count=9, Cause=13)
- EPC_CS, 14; EPC_SEL, 0: register read implicitly by eret
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- hold  in  1  pipeline freeze; tracker does not advance
- flush  in  DEPTH+1  bit 0 kills the ID instruction; bit k kills tracker entry k
- id_valid  in  1  ID holds a real instruction
- id_cp0op  in  3  001 mfc0, 010 mtc0, 011 barrier (exception commit), 100 eret, others none
- id_cs  in  5  CP0 register number
- id_sel  in  3  CP0 select
- id_wdata  in  DW  mtc0 write data (already GPR-forwarded)
- fwd_stage  out  $clog2(DEPTH+1)  0 = no forward, k = forward from entry k (DEPTH=3 gives 2-bit code 01/10/11 = EX/MEM/WB)
- fwd_data  out  DW  data of the selected entry, 0 when fwd_stage=0
- cp0_stall  out  1  ID must hold; a bubble is inserted into entry 1
- pending_cnt  out  $clog2(DEPTH+1)  valid mtc0 entries held

## Operation
- Entry k = {v, op, cs, sel, data}, k=1..DEPTH. Only op 010 and 011 are captured; all other ops enter as v=0.
- Lookup target: mfc0 uses (id_cs, id_sel); eret uses (EPC_CS, EPC_SEL). The lookup is active only when id_valid && !flush[0].
- Match: v && op==010 && cs/sel equal to the target. Pick the smallest matching k (youngest).
- Barrier: when any valid op==011 entry has index j, matches at k>j are ignored. This replaces the old EX-only check.
- NOFWD: if the target sel==0 && NOFWD_MASK[target cs] && a match exists, then cp0_stall=1 and fwd_stage=0.
- Advance when !hold:
  - Entry k+1 <= entry k.
  - Entry 1 <= the ID op if it is capturable && id_valid && !flush[0] && !cp0_stall; otherwise entry 1 gets a bubble.
  - Entry DEPTH falls out (retired to the CP0 file).
- Flush: flush[k] clears v of entry k before the shift in the same edge. The flush applies even when hold=1.
- pending_cnt: registered count of v && op==010 entries after the update.

## Timing
- Reset (rst_n=0 at edge): all v=0, pending_cnt=0. Consequently fwd_stage=0, fwd_data=0, cp0_stall=0.
- fwd_stage, fwd_data and cp0_stall are combinational from the registered entries plus the ID inputs; zero-cycle lookup.
- An mtc0 accepted at edge t is visible as entry 1 from cycle t+1. It is at entry k after k advancing edges and is gone after DEPTH+1 advances.
- Under hold=1, outputs track the ID inputs but the entries (except flushed ones) are frozen.
- A NOFWD stall lasts until the matching entry retires: DEPTH−k+1 advancing cycles for a match at entry k.
- Reset mid-operation discards all pending entries. The pipeline flush at reset owns correctness.
- Simultaneous flush[k] and a match at k: the match is evaluated on pre-flush state in that cycle; the entry is gone next cycle.

## Test plan
- **Basic forward path:** mtc0 cs=12 sel=0 data=0x0000_FF01, then mfc0 cs=12 next cycle -> fwd_stage=1, data 0x0000_FF01. With one and two bubbles between them -> fwd_stage=2, then 3. With three bubbles -> fwd_stage=0.
- **Youngest wins:** mtc0 EPC=0x100, then mtc0 EPC=0x200, then eret -> fwd_stage=1, fwd_data=0x200.
- **Barrier:** mtc0 cs=12=0x1, then op 011, then mfc0 cs=12 -> fwd_stage=0, because the match at k=2 lies behind the barrier at k=1.
- **NOFWD interlock:** mtc0 cs=9=0x55, then mfc0 cs=9 -> cp0_stall=1 for exactly 3 cycles (DEPTH=3, match at entry 1), then fwd_stage=0 and cp0_stall=0. pending_cnt goes 1→0.
- **Hold and flush:** with hold=1 for 4 cycles, fwd_stage stays 1 throughout. Then flush[1] pulse -> next cycle fwd_stage=0 and pending_cnt=0. Separately, mtc0 with flush[0]=1 -> not captured.
- **Reset and parameter sweep:** rst_n=0 with 3 entries valid -> all outputs 0 on the next cycle. Rerun the first scenario with DEPTH=5 and DW=64 -> fwd_stage reaches 5 and data is intact.
